// File: rtl/exe0_stage.sv
// exe0_stage -- execute stage fed by Dec0's registered token, draining into Exe1.
//
// Single-cycle ops (ALU, shifts, memory-address pass) are loaded straight into the
// output register one edge after acceptance. Multiply tokens are latched and run
// through an iterative shift-add unit that retires MUL_STEP multiplier bits per cycle.
// Signed products use magnitudes, then the 64-bit product is negated if the operand
// signs differ.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   valid_i_exe0      token valid from Dec0
//   ready_o_exe0      stage accepts a token this cycle (low during reset and multiply)
//   node/gen/opr0/opr1/mem_wen/dopc/ins/mul_ins/sh_ins _i_exe0   token fields
//   valid_o_exe0      result token valid toward Exe1
//   ready_i_exe0      Exe1 accepts the result
//   node/gen/result/opr1/mem_wen/ins _o_exe0                    result token fields
//   busy_o_exe0       multiplier sequencer is not idle
module exe0_stage #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i_exe0,
    output logic              ready_o_exe0,
    input  logic [15:0]       node_i_exe0,
    input  logic [11:0]       gen_i_exe0,
    input  logic [DATA_W-1:0] opr0_i_exe0,
    input  logic [DATA_W-1:0] opr1_i_exe0,
    input  logic              mem_wen_i_exe0,
    input  logic [9:0]        dopc_i_exe0,
    input  logic [26:0]       ins_i_exe0,
    input  logic              mul_ins_i_exe0,
    input  logic              sh_ins_i_exe0,
    output logic              valid_o_exe0,
    input  logic              ready_i_exe0,
    output logic [15:0]       node_o_exe0,
    output logic [11:0]       gen_o_exe0,
    output logic [DATA_W-1:0] result_o_exe0,
    output logic [DATA_W-1:0] opr1_o_exe0,
    output logic              mem_wen_o_exe0,
    output logic [26:0]       ins_o_exe0,
    output logic              busy_o_exe0
);
    localparam int K      = DATA_W / MUL_STEP;
    localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
    localparam int SH_W   = $clog2(DATA_W);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

    state_t              state_q, state_d;
    // Output register toward Exe1.
    logic                valid_q, valid_d;
    logic [15:0]         node_q, node_d;
    logic [11:0]         gen_q, gen_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   opr1_q, opr1_d;
    logic                mem_wen_q, mem_wen_d;
    logic [26:0]         ins_q, ins_d;
    // Multiplier datapath and the latched multiply token.
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                neg_q, neg_d;
    logic                hi_q, hi_d;
    logic [15:0]         m_node_q, m_node_d;
    logic [11:0]         m_gen_q, m_gen_d;
    logic [DATA_W-1:0]   m_opr1_q, m_opr1_d;
    logic [26:0]         m_ins_q, m_ins_d;

    logic                slot_free, accept, is_mul, load_op, load_mul;
    logic [SH_W-1:0]     sh_amt;
    logic signed [DATA_W-1:0] sra_val;
    logic [PROD_W-1:0]   rol_wide;
    logic [DATA_W-1:0]   op_res;
    logic                neg0, neg1;
    logic [DATA_W-1:0]   mag0, mag1;
    logic [PROD_W-1:0]   partial, acc_step, mag_prod, prod;
    logic [DATA_W-1:0]   mul_res;
    logic                unused_dopc;

    assign unused_dopc  = ^dopc_i_exe0[9:8];
    assign slot_free    = !valid_q || ready_i_exe0;
    assign ready_o_exe0 = !rst && (state_q == ST_IDLE) && slot_free;
    assign accept       = valid_i_exe0 && ready_o_exe0;
    // mem_wen outranks mul_ins, so a store flagged as multiply still takes the single-cycle path.
    assign is_mul       = mul_ins_i_exe0 && !mem_wen_i_exe0;

    // Single-cycle result: memory address, shift or ALU.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no path infers a latch.
        sh_amt   = opr1_i_exe0[SH_W-1:0];
        sra_val  = $signed(opr0_i_exe0) >>> sh_amt;
        // Upper half of {a,a} shifted left is a rotated left.
        rol_wide = {opr0_i_exe0, opr0_i_exe0} << sh_amt;
        op_res   = '0;
        if (mem_wen_i_exe0) begin
            op_res = opr0_i_exe0;
        end else if (sh_ins_i_exe0) begin
            unique case (dopc_i_exe0[5:4])
                2'b00: op_res = opr0_i_exe0 << sh_amt;
                2'b01: op_res = opr0_i_exe0 >> sh_amt;
                2'b10: op_res = sra_val;
                2'b11: op_res = rol_wide[PROD_W-1:DATA_W];
            endcase
        end else begin
            case (dopc_i_exe0[3:0])
                4'h0: op_res = opr0_i_exe0 + opr1_i_exe0;
                4'h1: op_res = opr0_i_exe0 - opr1_i_exe0;
                4'h2: op_res = opr0_i_exe0 & opr1_i_exe0;
                4'h3: op_res = opr0_i_exe0 | opr1_i_exe0;
                4'h4: op_res = opr0_i_exe0 ^ opr1_i_exe0;
                4'h5: op_res = ~opr0_i_exe0;
                4'h6: op_res = opr0_i_exe0;
                4'h7: op_res = opr1_i_exe0;
                4'h8: op_res = {{(DATA_W-1){1'b0}}, $signed(opr0_i_exe0) < $signed(opr1_i_exe0)};
                4'h9: op_res = {{(DATA_W-1){1'b0}}, opr0_i_exe0 < opr1_i_exe0};
                4'hA: op_res = {{(DATA_W-1){1'b0}}, opr0_i_exe0 == opr1_i_exe0};
                default: op_res = '0;
            endcase
        end
    end

    // Operand magnitudes for the multiplier; dopc[7] selects signed.
    always_comb begin
        neg0 = dopc_i_exe0[7] && opr0_i_exe0[DATA_W-1];
        neg1 = dopc_i_exe0[7] && opr1_i_exe0[DATA_W-1];
        mag0 = neg0 ? ({DATA_W{1'b0}} - opr0_i_exe0) : opr0_i_exe0;
        mag1 = neg1 ? ({DATA_W{1'b0}} - opr1_i_exe0) : opr1_i_exe0;
    end

    // One shift-add iteration, plus the final signed/half selection.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
        acc_step = acc_q + partial;
        // The last iteration's sum is used directly so the result loads on the K-th edge.
        mag_prod = (state_q == ST_HOLD) ? acc_q : acc_step;
        prod     = neg_q ? ({PROD_W{1'b0}} - mag_prod) : mag_prod;
        mul_res  = hi_q ? prod[PROD_W-1:DATA_W] : prod[DATA_W-1:0];
    end

    // Sequencer next state and output-register next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        m_node_d  = m_node_q;
        m_gen_d   = m_gen_q;
        m_opr1_d  = m_opr1_q;
        m_ins_d   = m_ins_q;
        valid_d   = valid_q;
        node_d    = node_q;
        gen_d     = gen_q;
        result_d  = result_q;
        opr1_d    = opr1_q;
        mem_wen_d = mem_wen_q;
        ins_d     = ins_q;
        load_op   = 1'b0;
        load_mul  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{DATA_W{1'b0}}, mag0};
                        mplier_d = mag1;
                        neg_d    = neg0 ^ neg1;
                        hi_d     = dopc_i_exe0[6];
                        m_node_d = node_i_exe0;
                        m_gen_d  = gen_i_exe0;
                        m_opr1_d = opr1_i_exe0;
                        m_ins_d  = ins_i_exe0;
                    end else begin
                        load_op = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    if (slot_free) begin
                        load_mul = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    load_mul = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_op) begin
            valid_d   = 1'b1;
            node_d    = node_i_exe0;
            gen_d     = gen_i_exe0;
            result_d  = op_res;
            opr1_d    = opr1_i_exe0;
            mem_wen_d = mem_wen_i_exe0;
            ins_d     = ins_i_exe0;
        end else if (load_mul) begin
            valid_d   = 1'b1;
            node_d    = m_node_q;
            gen_d     = m_gen_q;
            result_d  = mul_res;
            opr1_d    = m_opr1_q;
            mem_wen_d = 1'b0;
            ins_d     = m_ins_q;
        end else if (ready_i_exe0) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the statement order.
        if (rst) begin
            // NOTE: the multiplier datapath is cleared too, so an aborted multiply leaves no stale partial product.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
            m_node_q  <= '0;
            m_gen_q   <= '0;
            m_opr1_q  <= '0;
            m_ins_q   <= '0;
            valid_q   <= 1'b0;
            node_q    <= '0;
            gen_q     <= '0;
            result_q  <= '0;
            opr1_q    <= '0;
            mem_wen_q <= 1'b0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            m_node_q  <= m_node_d;
            m_gen_q   <= m_gen_d;
            m_opr1_q  <= m_opr1_d;
            m_ins_q   <= m_ins_d;
            valid_q   <= valid_d;
            node_q    <= node_d;
            gen_q     <= gen_d;
            result_q  <= result_d;
            opr1_q    <= opr1_d;
            mem_wen_q <= mem_wen_d;
            ins_q     <= ins_d;
        end
    end

    assign valid_o_exe0   = valid_q;
    assign node_o_exe0    = node_q;
    assign gen_o_exe0     = gen_q;
    assign result_o_exe0  = result_q;
    assign opr1_o_exe0    = opr1_q;
    assign mem_wen_o_exe0 = mem_wen_q;
    assign ins_o_exe0     = ins_q;
    assign busy_o_exe0    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exe0_stage.sv
// Testbench for exe0_stage: directed latency/boundary cases plus a randomized token
// stream, all checked against an in-order behavioural model of the stage.
module tb_exe0_stage;

    typedef struct packed {
        logic [15:0] node;
        logic [11:0] gen;
        logic [31:0] opr0;
        logic [31:0] opr1;
        logic        mem_wen;
        logic [9:0]  dopc;
        logic [26:0] ins;
        logic        mul;
        logic        sh;
    } tok_t;

    typedef struct packed {
        logic [31:0] result;
        logic [15:0] node;
        logic [11:0] gen;
        logic [31:0] opr1;
        logic        mem_wen;
        logic [26:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i_exe0 = 1'b0;
    logic        ready_o_exe0;
    logic [15:0] node_i_exe0 = '0;
    logic [11:0] gen_i_exe0 = '0;
    logic [31:0] opr0_i_exe0 = '0;
    logic [31:0] opr1_i_exe0 = '0;
    logic        mem_wen_i_exe0 = 1'b0;
    logic [9:0]  dopc_i_exe0 = '0;
    logic [26:0] ins_i_exe0 = '0;
    logic        mul_ins_i_exe0 = 1'b0;
    logic        sh_ins_i_exe0 = 1'b0;
    logic        valid_o_exe0;
    logic        ready_i_exe0 = 1'b0;
    logic [15:0] node_o_exe0;
    logic [11:0] gen_o_exe0;
    logic [31:0] result_o_exe0;
    logic [31:0] opr1_o_exe0;
    logic        mem_wen_o_exe0;
    logic [26:0] ins_o_exe0;
    logic        busy_o_exe0;

    int   n_vec = 0;
    int   n_err = 0;
    logic rand_ready = 1'b0;
    exp_t exp_q[$];

    exe0_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i_exe0   (valid_i_exe0),
        .ready_o_exe0   (ready_o_exe0),
        .node_i_exe0    (node_i_exe0),
        .gen_i_exe0     (gen_i_exe0),
        .opr0_i_exe0    (opr0_i_exe0),
        .opr1_i_exe0    (opr1_i_exe0),
        .mem_wen_i_exe0 (mem_wen_i_exe0),
        .dopc_i_exe0    (dopc_i_exe0),
        .ins_i_exe0     (ins_i_exe0),
        .mul_ins_i_exe0 (mul_ins_i_exe0),
        .sh_ins_i_exe0  (sh_ins_i_exe0),
        .valid_o_exe0   (valid_o_exe0),
        .ready_i_exe0   (ready_i_exe0),
        .node_o_exe0    (node_o_exe0),
        .gen_o_exe0     (gen_o_exe0),
        .result_o_exe0  (result_o_exe0),
        .opr1_o_exe0    (opr1_o_exe0),
        .mem_wen_o_exe0 (mem_wen_o_exe0),
        .ins_o_exe0     (ins_o_exe0),
        .busy_o_exe0    (busy_o_exe0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] model(input tok_t t);
        logic [31:0] a, b, r;
        logic [63:0] p;
        longint      sp;
        int          s;
        a = t.opr0;
        b = t.opr1;
        s = int'(b[4:0]);
        if (t.mem_wen) return a;
        if (t.mul) begin
            if (t.dopc[7]) begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                p  = sp;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            return t.dopc[6] ? p[63:32] : p[31:0];
        end
        if (t.sh) begin
            r = a;
            case (t.dopc[5:4])
                2'b00: r = a << s;
                2'b01: r = a >> s;
                2'b10: for (int i = 0; i < s; i++) r = {r[31], r[31:1]};
                default: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
            endcase
            return r;
        end
        case (t.dopc[3:0])
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return a;
            4'h7: return b;
            4'h8: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t expect_of(input tok_t t);
        exp_t e;
        e.result  = model(t);
        e.node    = t.node;
        e.gen     = t.gen;
        e.opr1    = t.opr1;
        e.mem_wen = t.mem_wen;
        e.ins     = t.ins;
        return e;
    endfunction

    function automatic tok_t mk(input logic [9:0] dopc, input logic sh, input logic mul,
                                input logic [31:0] a, input logic [31:0] b);
        tok_t t;
        t.node    = 16'($urandom);
        t.gen     = 12'($urandom);
        t.ins     = 27'($urandom);
        t.opr0    = a;
        t.opr1    = b;
        t.mem_wen = 1'b0;
        t.dopc    = dopc;
        t.mul     = mul;
        t.sh      = sh;
        return t;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic tok_t rand_tok();
        tok_t t;
        int   k;
        t = mk(10'($urandom), 1'b0, 1'b0, rand_operand(), rand_operand());
        k = $urandom_range(0, 7);
        t.mem_wen = (k == 0);
        t.mul     = (k == 1 || k == 2);
        t.sh      = (k == 3 || k == 4);
        if ($urandom_range(0, 9) == 0) begin
            t.mul = 1'($urandom);
            t.sh  = 1'($urandom);
        end
        return t;
    endfunction

    // Scoreboard: outputs sampled on the falling edge, away from the active edge.
    exp_t        e_head;
    tok_t        cur_tok;
    logic        stall_prev = 1'b0;
    logic [56:0] snap_ctl;
    logic [31:0] snap_res, snap_opr1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stable_ctl", {valid_o_exe0, node_o_exe0, gen_o_exe0, mem_wen_o_exe0, ins_o_exe0}, snap_ctl);
                check("stable_result", result_o_exe0, snap_res);
                check("stable_opr1", opr1_o_exe0, snap_opr1);
            end
            if (valid_o_exe0 && ready_i_exe0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: result 0x%0h delivered, no token outstanding (t=%0t)",
                             result_o_exe0, $time);
                end else begin
                    e_head = exp_q.pop_front();
                    check("sb_result", result_o_exe0, e_head.result);
                    check("sb_node", node_o_exe0, e_head.node);
                    check("sb_gen", gen_o_exe0, e_head.gen);
                    check("sb_opr1", opr1_o_exe0, e_head.opr1);
                    check("sb_mem_wen", mem_wen_o_exe0, e_head.mem_wen);
                    check("sb_ins", ins_o_exe0, e_head.ins);
                end
            end
            stall_prev = valid_o_exe0 && !ready_i_exe0;
            snap_ctl   = {valid_o_exe0, node_o_exe0, gen_o_exe0, mem_wen_o_exe0, ins_o_exe0};
            snap_res   = result_o_exe0;
            snap_opr1  = opr1_o_exe0;
            if (valid_i_exe0 && ready_o_exe0) begin
                cur_tok.node    = node_i_exe0;
                cur_tok.gen     = gen_i_exe0;
                cur_tok.opr0    = opr0_i_exe0;
                cur_tok.opr1    = opr1_i_exe0;
                cur_tok.mem_wen = mem_wen_i_exe0;
                cur_tok.dopc    = dopc_i_exe0;
                cur_tok.ins     = ins_i_exe0;
                cur_tok.mul     = mul_ins_i_exe0;
                cur_tok.sh      = sh_ins_i_exe0;
                exp_q.push_back(expect_of(cur_tok));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) ready_i_exe0 = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a token at posedge+1 and hold it until accepted; returns at accept edge +1.
    task automatic send(input tok_t t, output int waited);
        valid_i_exe0   = 1'b1;
        node_i_exe0    = t.node;
        gen_i_exe0     = t.gen;
        opr0_i_exe0    = t.opr0;
        opr1_i_exe0    = t.opr1;
        mem_wen_i_exe0 = t.mem_wen;
        dopc_i_exe0    = t.dopc;
        ins_i_exe0     = t.ins;
        mul_ins_i_exe0 = t.mul;
        sh_ins_i_exe0  = t.sh;
        waited = 0;
        @(negedge clk);
        while (!ready_o_exe0 && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!ready_o_exe0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, want acceptance", waited);
        end
        @(posedge clk);
        #1;
        valid_i_exe0 = 1'b0;
    endtask

    task automatic run_alu(input string name, input tok_t t, input logic [31:0] expv);
        int w;
        ready_i_exe0 = 1'b1;
        send(t, w);
        check({name, "_valid"}, valid_o_exe0, 1);
        check({name, "_result"}, result_o_exe0, expv);
        check({name, "_node"}, node_o_exe0, t.node);
        check({name, "_gen"}, gen_o_exe0, t.gen);
        check({name, "_ins"}, ins_o_exe0, t.ins);
    endtask

    task automatic run_mul(input string name, input tok_t t, input logic [31:0] expv);
        int   w, cyc;
        logic ready_seen;
        ready_i_exe0 = 1'b1;
        send(t, w);
        cyc = 0;
        ready_seen = 1'b0;
        while (!valid_o_exe0 && cyc < 64) begin
            if (ready_o_exe0) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, 16);
        check({name, "_ready_low"}, ready_seen, 0);
        check({name, "_result"}, result_o_exe0, expv);
    endtask

    task automatic drain();
        int c;
        c = 0;
        rand_ready   = 1'b0;
        ready_i_exe0 = 1'b1;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tok_t t;
        int   w, cyc, total;

        // Model pins against hand-computed values.
        check("model_add", model(mk(10'h000, 0, 0, 32'd5, 32'd7)), 32'h0000_000C);
        check("model_sra", model(mk(10'h020, 1, 0, 32'h8000_0000, 32'd4)), 32'hF800_0000);
        check("model_smul_lo", model(mk(10'h080, 0, 1, 32'hFFFF_FFFD, 32'd7)), 32'hFFFF_FFEB);
        check("model_umul_hi", model(mk(10'h040, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 32'hFFFF_FFFE);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o_exe0, 0);
        check("rst_valid", valid_o_exe0, 0);
        check("rst_busy", busy_o_exe0, 0);
        check("rst_result", result_o_exe0, 0);
        check("rst_node", node_o_exe0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready_o_exe0, 1);
        @(posedge clk);
        #1;

        // Single-cycle ops, latency 1.
        run_alu("add", mk(10'h000, 0, 0, 32'd5, 32'd7), 32'h0000_000C);
        run_alu("sub", mk(10'h001, 0, 0, 32'd0, 32'd1), 32'hFFFF_FFFF);
        run_alu("sra", mk(10'h020, 1, 0, 32'h8000_0000, 32'd4), 32'hF800_0000);
        run_alu("rol", mk(10'h030, 1, 0, 32'h8000_0001, 32'd1), 32'h0000_0003);

        // Multiplies.
        run_mul("smul_lo", mk(10'h080, 0, 1, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFEB);
        run_mul("smul_hi", mk(10'h0C0, 0, 1, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFFF);
        run_mul("umul_lo", mk(10'h000, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0001);

        // Multiply completing while Exe1 is not ready: result held, then one beat.
        ready_i_exe0 = 1'b1;
        send(mk(10'h040, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), w);
        repeat (5) @(posedge clk);
        #1;
        ready_i_exe0 = 1'b0;
        cyc = 0;
        while (!valid_o_exe0 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stall_latency", cyc + 5, 16);
        check("stall_result", result_o_exe0, 32'hFFFF_FFFE);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("stall_hold_valid", valid_o_exe0, 1);
            check("stall_hold_result", result_o_exe0, 32'hFFFF_FFFE);
        end
        ready_i_exe0 = 1'b1;
        @(posedge clk);
        #1;
        check("stall_one_beat", valid_o_exe0, 0);

        // Reset five cycles into a multiply.
        send(mk(10'h000, 0, 1, 32'd1234, 32'd5678), w);
        repeat (5) @(posedge clk);
        #1;
        check("mid_mul_busy", busy_o_exe0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", valid_o_exe0, 0);
        check("abort_busy", busy_o_exe0, 0);
        rst = 1'b0;
        run_alu("add_after_abort", mk(10'h000, 0, 0, 32'd1, 32'd1), 32'h0000_0002);

        // 20 back-to-back ADDs against a randomly stalling Exe1.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(mk(10'h000, 0, 0, $urandom, $urandom), w);
        drain();

        // 20 back-to-back ADDs with Exe1 always ready: no bubbles.
        total = 0;
        for (int i = 0; i < 20; i++) begin
            send(mk(10'h000, 0, 0, $urandom, $urandom), w);
            total += w;
            check("stream_valid", valid_o_exe0, 1);
        end
        check("stream_no_gaps", total, 0);
        drain();

        // Randomized mixed stream with idle gaps and back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            t = rand_tok();
            send(t, w);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
